// File: rtl/txfifo_axis_reader.sv
// Transmit-path drain engine: reads a byte length from the control FIFO, then streams the
// matching 64-bit data beats out as an AXI-Stream master through a two-entry buffer.
module txfifo_axis_reader #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LENW  = 16
) (
  input  logic               rdclk,
  input  logic               reset_,
  input  logic               ctl_rdempty,
  output logic               ctl_rden,
  input  logic [LENW-1:0]    ctl_dataout,
  input  logic               rdempty,
  output logic               rden,
  input  logic [WIDTH-1:0]   dataout,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [WIDTH-1:0]   m_tdata,
  output logic [WIDTH/8-1:0] m_tkeep,
  output logic               m_tlast,
  output logic               pkt_done,
  output logic               len_err,
  output logic               busy
);

  localparam int unsigned KeepW = WIDTH / 8;
  localparam int unsigned CntW  = 13;

  typedef enum logic [1:0] {StIdle, StLen, StStream} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   rd_rem_q, rd_rem_d;
  logic [CntW-1:0]   out_rem_q, out_rem_d;
  logic [2:0]        len_lo_q, len_lo_d;
  logic              inflight_q;
  logic [WIDTH-1:0]  buf_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;

  logic              pop;
  logic [2:0]        fill_level;
  logic [LENW:0]     len_plus;
  logic [CntW-1:0]   beats;
  logic [KeepW-1:0]  keep_last;

  assign len_plus   = {1'b0, ctl_dataout} + (LENW + 1)'(7);
  assign beats      = CntW'(len_plus >> 3);
  // Slots already spoken for: buffered beats plus the read whose data lands this cycle.
  assign fill_level = {1'b0, occ_q} + {2'b00, inflight_q};

  assign busy      = (state_q != StIdle);
  assign m_tvalid  = (state_q == StStream) && (occ_q != 2'd0);
  assign pop       = m_tvalid && m_tready;
  assign m_tlast   = m_tvalid && (out_rem_q == CntW'(1));
  assign m_tdata   = m_tvalid ? buf_q[rd_ptr_q] : '0;
  assign keep_last = (len_lo_q == 3'd0) ? {KeepW{1'b1}}
                                        : {KeepW{1'b1}} >> (4'd8 - {1'b0, len_lo_q});

  always_comb begin
    m_tkeep = '0;
    if (m_tvalid) begin
      m_tkeep = m_tlast ? keep_last : {KeepW{1'b1}};
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_rem_d  = rd_rem_q;
    out_rem_d = out_rem_q;
    len_lo_d  = len_lo_q;
    ctl_rden  = 1'b0;
    rden      = 1'b0;
    len_err   = 1'b0;
    pkt_done  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!ctl_rdempty) begin
          ctl_rden = 1'b1;
          state_d  = StLen;
        end
      end
      StLen: begin
        len_lo_d = ctl_dataout[2:0];
        if (ctl_dataout == '0) begin
          len_err = 1'b1;
          state_d = StIdle;
        end else begin
          rd_rem_d  = beats;
          out_rem_d = beats;
          state_d   = StStream;
        end
      end
      StStream: begin
        // Never let buffered + in-flight words exceed the two buffer slots.
        rden = (rd_rem_q != '0) && !rdempty && (fill_level < (3'd2 + {2'b00, pop}));
        if (rden) begin
          rd_rem_d = rd_rem_q - CntW'(1);
        end
        if (pop) begin
          out_rem_d = out_rem_q - CntW'(1);
          if (m_tlast) begin
            pkt_done = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rdclk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= StIdle;
      rd_rem_q  <= '0;
      out_rem_q <= '0;
      len_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_rem_q  <= rd_rem_d;
      out_rem_q <= out_rem_d;
      len_lo_q  <= len_lo_d;
    end
  end

  always_ff @(posedge rdclk or negedge reset_) begin
    if (!reset_) begin
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      inflight_q <= rden;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= dataout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule
